// File: rtl/nco_pkg.sv
// Shared definitions for the NCO ROM scheduler: FSM states, LFSR constants
// and the quarter-wave address offset used to derive sine from cosine.
package nco_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COS,
    ST_SIN,
    ST_CAP,
    ST_HOLD
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // sin(x) = cos(x - pi/2): step back a quarter of the table, wrapping mod depth
  function automatic logic [31:0] quarter_back(input logic [31:0] addr,
                                               input int unsigned depth);
    return (addr - 32'(depth / 4)) & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/nco_lfsr.sv
// 16-bit Galois LFSR used to dither the NCO phase. Only exists in builds
// with NCO_DITHER_EN defined; the undithered build carries no LFSR at all.
`ifdef NCO_DITHER_EN
module nco_lfsr
  import nco_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Galois step: shift right, fold taps in when the outgoing bit is set
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // Step once per request; reset returns to the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            lfsr_q <= LFSR_SEED;
    else if (advance_i) lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule
`endif

// File: rtl/nco_rom_sched.sv
// NCO that time-shares one registered cosine ROM between the cos and sin
// lookups: COS issues the cos address, SIN issues the quarter-back address
// and steps the phase, CAP/HOLD collect the two read results. One pair per
// four cycles when the consumer keeps up.
// Optional feature: define NCO_DITHER_EN to add LFSR phase dither.
module nco_rom_sched
  import nco_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4096,
  parameter int ACC_W  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ACC_W-1:0]  i_ftw,
  input  logic              i_ftw_load,
  input  logic              i_phase_clr,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WIDTH-1:0]  i_rom_data,
  output logic [WIDTH-1:0]  o_cos,
  output logic [WIDTH-1:0]  o_sin,
  output logic              o_valid,
  input  logic              i_ready
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    ftw_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    cos_q, cos_d;
  logic [WIDTH-1:0]    sin_q, sin_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   cos_addr, sin_addr;

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr;

  // Advances on the COS->SIN edge, so it is constant while a cos address is formed
  nco_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .advance_i (state_q == ST_COS),
    .value_o   (lfsr)
  );

  assign cos_addr = ADDR_W'((acc_q + (ACC_W'(lfsr) << (ACC_W - ADDR_W - 16)))
                            >> (ACC_W - ADDR_W));
`else
  assign cos_addr = acc_q[ACC_W-1 -: ADDR_W];
`endif

  assign sin_addr = ADDR_W'(quarter_back(32'(cos_addr), DEPTH));

  // Next-state and datapath updates; phase clear overrides the FTW add
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_COS;
          addr_d  = cos_addr;
        end
      end
      ST_COS: begin
        state_d = ST_SIN;
        addr_d  = sin_addr;
        acc_d   = acc_q + ftw_q;
      end
      ST_SIN: begin
        state_d = ST_CAP;
        cos_d   = i_rom_data;
      end
      ST_CAP: begin
        state_d = ST_HOLD;
        sin_d   = i_rom_data;
        valid_d = 1'b1;
      end
      ST_HOLD: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          if (i_en) begin
            state_d = ST_COS;
            addr_d  = cos_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_phase_clr) acc_d = '0;
  end

  // Scheduler and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      addr_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      valid_q <= valid_d;
    end
  end

  // Tuning word; a load on the same edge as an add takes effect afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ftw_q <= '0;
    else if (i_ftw_load) ftw_q <= i_ftw;
  end

  assign o_rom_addr = addr_q;
  assign o_cos      = cos_q;
  assign o_sin      = sin_q;
  assign o_valid    = valid_q;

endmodule

// File: doc/nco_rom_sched.md
NCO_ROM_SCHED -- requirements
Module: nco_rom_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, ROM sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 4096, ROM entries (power of two); ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have parameter ACC_W, default 32, phase accumulator width; ACC_W >= ADDR_W + 16.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_en  input  1  run request; generate samples while high.
REQ-007 i_ftw  input  ACC_W  frequency tuning word.
REQ-008 i_ftw_load  input  1  capture i_ftw into internal FTW register.
REQ-009 i_phase_clr  input  1  zero the phase accumulator.
REQ-010 o_rom_addr  output  ADDR_W  registered address to the single-port cosine ROM (1-cycle registered read).
REQ-011 i_rom_data  input  WIDTH  ROM read data.
REQ-012 o_cos, o_sin  output  WIDTH each  sample pair.
REQ-013 o_valid  output  1  sample pair valid; i_ready  input  1  consumer accepts.

Function
REQ-014 States: IDLE, COS, SIN, CAP, HOLD; one ROM shared by cos and sin lookups.
REQ-015 IDLE->COS on edge sampling i_en=1; else stay IDLE.
REQ-016 Edge entering COS: o_rom_addr <= cos_addr = phase[ACC_W-1 -: ADDR_W].
REQ-017 COS->SIN: o_rom_addr <= (cos_addr - DEPTH/4) mod DEPTH; accumulator <= accumulator + FTW (mod 2^ACC_W).
REQ-018 SIN->CAP: cos register <= i_rom_data; CAP->HOLD: sin register <= i_rom_data, o_valid <= 1.
REQ-019 o_valid rises 4 edges after the IDLE edge sampling i_en=1; throughput 1 pair per 4 cycles.
REQ-020 HOLD: o_cos, o_sin, o_valid, o_rom_addr stable until o_valid && i_ready.
REQ-021 On handshake: o_valid <= 0; next state COS if i_en=1, else IDLE.
REQ-022 i_en deasserted mid-sample: current pair completes and handshakes, then IDLE.
REQ-023 i_ftw_load: FTW <= i_ftw any state; coincident accumulator update uses old FTW.
REQ-024 i_phase_clr: accumulator <= 0 any state; wins over coincident FTW add.
REQ-025 Accumulator wraps modulo 2^ACC_W silently; sin address wraps modulo DEPTH.

Reset
REQ-026 rst asserted: state IDLE, accumulator 0, FTW 0, o_rom_addr 0, o_cos 0, o_sin 0, o_valid 0, immediately and asynchronously.
REQ-027 rst mid-sample: sample discarded, no o_valid pulse; restart needs i_en sampled in IDLE after release.

Configuration
REQ-028 Macro NCO_DITHER_EN defined: 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 0xACE1, reset to seed) advances once per COS->SIN transition; cos_addr taken from accumulator + (LFSR << (ACC_W-ADDR_W-16)).
REQ-029 NCO_DITHER_EN undefined: no LFSR logic; cos_addr is accumulator top ADDR_W bits exactly.

Structure
REQ-030 Package nco_pkg SHALL hold the state enum, LFSR seed/tap constants and the quarter-wave offset function.
REQ-031 LFSR SHALL be sub-module nco_lfsr (clk, rst, advance, 16-bit value), instantiated only under NCO_DITHER_EN.
REQ-032 ROM SHALL stay outside this block; bench and top connect the existing single-port ROM.

Verification (dither off, DEPTH 4096, ACC_W 32)
REQ-033 Reset: rst high mid-SIN -> all outputs 0 same cycle, no o_valid after release.
REQ-034 FTW 0x00100000 load, i_en=1, i_ready=1 -> cos addrs 0,1,2; sin addrs 3072,3073,3074; o_valid every 4th cycle.
REQ-035 FTW 0x80000000 -> cos addrs 0,2048,0; sin addrs 3072,1024,3072.
REQ-036 i_ready low 10 cycles in HOLD -> o_cos/o_sin/o_rom_addr unchanged, o_valid high; one pair accepted on release.
REQ-037 i_phase_clr and COS->SIN together with FTW 0x00100000 -> next cos addr 0; i_ftw_load same edge -> old FTW used once.
REQ-038 i_en dropped during SIN -> pair delivered, then IDLE, o_rom_addr frozen.
